// File: rtl/vga_line_mux_reg_if.sv
// Bus bundle for the registered 15-way VGA line selector: select, data words d0..d14, registered result o_q.
interface vga_line_mux_reg_if #(
   parameter int unsigned DATA_WIDTH   = 12,
   parameter int unsigned SELECT_WIDTH = 4
);
   logic [SELECT_WIDTH-1:0] select;
   logic [DATA_WIDTH-1:0]   d0;
   logic [DATA_WIDTH-1:0]   d1;
   logic [DATA_WIDTH-1:0]   d2;
   logic [DATA_WIDTH-1:0]   d3;
   logic [DATA_WIDTH-1:0]   d4;
   logic [DATA_WIDTH-1:0]   d5;
   logic [DATA_WIDTH-1:0]   d6;
   logic [DATA_WIDTH-1:0]   d7;
   logic [DATA_WIDTH-1:0]   d8;
   logic [DATA_WIDTH-1:0]   d9;
   logic [DATA_WIDTH-1:0]   d10;
   logic [DATA_WIDTH-1:0]   d11;
   logic [DATA_WIDTH-1:0]   d12;
   logic [DATA_WIDTH-1:0]   d13;
   logic [DATA_WIDTH-1:0]   d14;
   logic [DATA_WIDTH-1:0]   o_q;

   modport master (
      output select, d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d12, d13, d14,
      input  o_q
   );

   modport slave (
      input  select, d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d12, d13, d14,
      output o_q
   );
endinterface

// File: rtl/vga_line_mux_reg.sv
// Registered 15-way data selector between the line-buffer read ports and the pixel stage.
// One clock of latency; out-of-range select loads zero.
module vga_line_mux_reg #(
   parameter int unsigned DATA_WIDTH   = 12,
   parameter int unsigned SELECT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   vga_line_mux_reg_if.slave    bus
);
   localparam int unsigned NUM_WORDS = 15;

   logic [DATA_WIDTH-1:0] words [NUM_WORDS];
   logic [DATA_WIDTH-1:0] o_d;

   always_comb begin
      words[0]  = bus.d0;
      words[1]  = bus.d1;
      words[2]  = bus.d2;
      words[3]  = bus.d3;
      words[4]  = bus.d4;
      words[5]  = bus.d5;
      words[6]  = bus.d6;
      words[7]  = bus.d7;
      words[8]  = bus.d8;
      words[9]  = bus.d9;
      words[10] = bus.d10;
      words[11] = bus.d11;
      words[12] = bus.d12;
      words[13] = bus.d13;
      words[14] = bus.d14;
   end

   // Any select value without a matching word falls through to zero.
   always_comb begin
      o_d = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (bus.select == SELECT_WIDTH'(i)) begin
            o_d = words[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.o_q <= '0;
      end else begin
         bus.o_q <= o_d;
      end
   end
endmodule

// File: tb/tb_vga_line_mux_reg.sv
// Self-checking bench for vga_line_mux_reg: directed scenarios plus randomized traffic vs. a reference model.
module tb_vga_line_mux_reg;
   localparam int unsigned DW = 12;
   localparam int unsigned SW = 4;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   logic [DW-1:0] d_arr [15];
   logic [SW-1:0] sel;
   logic [DW-1:0] exp_q;

   vga_line_mux_reg_if #(.DATA_WIDTH(DW), .SELECT_WIDTH(SW)) bus ();

   vga_line_mux_reg #(.DATA_WIDTH(DW), .SELECT_WIDTH(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the word picked by select, or zero when reset or out of range.
   function automatic logic [DW-1:0] model(input logic rst, input logic [SW-1:0] s);
      int idx;
      idx = int'(s);
      if (rst) return '0;
      if (idx >= 15) return '0;
      return d_arr[idx];
   endfunction

   task automatic drive();
      bus.select = sel;
      bus.d0  = d_arr[0];  bus.d1  = d_arr[1];  bus.d2  = d_arr[2];
      bus.d3  = d_arr[3];  bus.d4  = d_arr[4];  bus.d5  = d_arr[5];
      bus.d6  = d_arr[6];  bus.d7  = d_arr[7];  bus.d8  = d_arr[8];
      bus.d9  = d_arr[9];  bus.d10 = d_arr[10]; bus.d11 = d_arr[11];
      bus.d12 = d_arr[12]; bus.d13 = d_arr[13]; bus.d14 = d_arr[14];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_default_data();
      int vals [15] = '{14, 4, 23, 5, 6, 8, 12, 23, 23, 1, 2, 3, 22, 33, 44};
      for (int i = 0; i < 15; i++) d_arr[i] = DW'(vals[i]);
   endtask

   task automatic test_reset();
      load_default_data();
      sel = SW'(3);
      reset = 1'b1;
      drive();
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (bus.o_q !== DW'(0)) begin
            tests_failed++;
            $display("FAIL reset_hold[%0d]: o_q=%0d expected 0", i, bus.o_q);
         end
      end
      reset = 1'b0;
      tick();
      tests_run++;
      if (bus.o_q !== DW'(5)) begin
         tests_failed++;
         $display("FAIL reset_release: o_q=%0d expected 5", bus.o_q);
      end
   endtask

   task automatic test_sweep();
      int expv [11] = '{14, 4, 23, 5, 6, 8, 12, 23, 23, 1, 2};
      for (int s = 0; s <= 10; s++) begin
         sel = SW'(s);
         drive();
         tick();
         tests_run++;
         if (bus.o_q !== DW'(expv[s])) begin
            tests_failed++;
            $display("FAIL sweep sel=%0d: o_q=%0d expected %0d", s, bus.o_q, expv[s]);
         end
      end
   endtask

   task automatic test_upper();
      int expv [4] = '{3, 22, 33, 44};
      for (int k = 0; k < 4; k++) begin
         sel = SW'(11 + k);
         drive();
         tick();
         tests_run++;
         if (bus.o_q !== DW'(expv[k])) begin
            tests_failed++;
            $display("FAIL upper sel=%0d: o_q=%0d expected %0d", 11 + k, bus.o_q, expv[k]);
         end
      end
   endtask

   task automatic test_out_of_range();
      sel = SW'(15);
      drive();
      tick();
      tests_run++;
      if (bus.o_q !== DW'(0)) begin
         tests_failed++;
         $display("FAIL out_of_range: o_q=%0d expected 0", bus.o_q);
      end
      sel = SW'(14);
      drive();
      tick();
      tests_run++;
      if (bus.o_q !== DW'(44)) begin
         tests_failed++;
         $display("FAIL after_oor sel=14: o_q=%0d expected 44", bus.o_q);
      end
   endtask

   task automatic test_data_tracking();
      sel = SW'(9);
      drive();
      tick();
      tests_run++;
      if (bus.o_q !== DW'(1)) begin
         tests_failed++;
         $display("FAIL track_initial: o_q=%0d expected 1", bus.o_q);
      end
      d_arr[9] = 12'hFFF;
      drive();
      #2;
      tests_run++;
      if (bus.o_q !== DW'(1)) begin
         tests_failed++;
         $display("FAIL track_no_comb_path: o_q=%0h expected 1", bus.o_q);
      end
      tick();
      tests_run++;
      if (bus.o_q !== 12'hFFF) begin
         tests_failed++;
         $display("FAIL track_update: o_q=%0h expected fff", bus.o_q);
      end
      d_arr[8] = 12'h5A5;
      drive();
      tick();
      tests_run++;
      if (bus.o_q !== 12'hFFF) begin
         tests_failed++;
         $display("FAIL track_other_input: o_q=%0h expected fff", bus.o_q);
      end
   endtask

   task automatic test_mid_reset();
      sel = SW'(13);
      drive();
      tick();
      tests_run++;
      if (bus.o_q !== DW'(33)) begin
         tests_failed++;
         $display("FAIL mid_reset_pre: o_q=%0d expected 33", bus.o_q);
      end
      reset = 1'b1;
      tick();
      tests_run++;
      if (bus.o_q !== DW'(0)) begin
         tests_failed++;
         $display("FAIL mid_reset_assert: o_q=%0d expected 0", bus.o_q);
      end
      reset = 1'b0;
      tick();
      tests_run++;
      if (bus.o_q !== DW'(33)) begin
         tests_failed++;
         $display("FAIL mid_reset_release: o_q=%0d expected 33", bus.o_q);
      end
   endtask

   // Random select (including 15), fresh data every cycle, occasional reset.
   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 15; i++) d_arr[i] = DW'($urandom);
         sel   = SW'($urandom_range(0, 15));
         reset = ($urandom_range(0, 15) == 0);
         drive();
         exp_q = model(reset, sel);
         tick();
         tests_run++;
         if (bus.o_q !== exp_q) begin
            tests_failed++;
            $display("FAIL random[%0d] sel=%0d rst=%0b: o_q=%0h expected %0h",
                     n, sel, reset, bus.o_q, exp_q);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      sel          = '0;
      for (int i = 0; i < 15; i++) d_arr[i] = '0;
      drive();
      #2;
      test_reset();
      test_sweep();
      test_upper();
      test_out_of_range();
      test_data_tracking();
      load_default_data();
      drive();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/vga_line_mux_reg.md
Name: vga_line_mux_reg

Overview:
- Registered 15-way data selector for the VGA line path.
- Picks one of 15 equal-width data words (e.g. line-buffer read ports d0..d14) using a binary select.
- Presents the picked word on a registered output, one clock after select/data are sampled.
- Sits between the line-buffer RAM read ports and the pixel/colour output stage.

Parameters:
- DATA_WIDTH, 12, width in bits of each data input and of o_q.
- SELECT_WIDTH, 4, width of select. Must be ≥4 so that indices 0..14 are encodable.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- select  input  SELECT_WIDTH  binary index of the data input to forward.
- d0  input  DATA_WIDTH  data word, index 0.
- d1  input  DATA_WIDTH  data word, index 1.
- d2 … d13  input  DATA_WIDTH each  data words, indices 2..13.
- d14  input  DATA_WIDTH  data word, index 14.
- o_q  output  DATA_WIDTH  registered selected word.

Behaviour:
- Single clock domain (clk).
- Reset is synchronous and active-high. If reset=1 at a rising edge of clk, o_q becomes 0 at that edge, regardless of select/data.
- Reset has priority over normal selection in the same cycle.
- Normal operation (reset=0): at each rising edge, o_q <= d[select], sampled from the select and data values present just before the edge.
- Latency: exactly 1 clock. No combinational path from select or d* to o_q.
- o_q holds its value between edges. No enable; the register updates every cycle.
- Out-of-range select:
  - select = 15, or any value ≥15 when SELECT_WIDTH > 4, loads o_q with 0.
  - Never X; never a repeat of the previous value.
- Data changes on the currently selected input appear on o_q one edge later, even if select is unchanged.
- Select change and data change in the same cycle: the new select and new data are both used at the next edge.
- Power-up before the first reset: o_q undefined in simulation. An initial value of 0 is permitted.
- Pure pass-through: no arithmetic, sign handling or width conversion; all bits are copied unchanged.
- X on select (simulation only): o_q is not required to be defined.

Test Plan:
- Reset: drive d0..d14 = 14,4,23,5,6,8,12,23,23,1,2,3,22,33,44, select=3, reset=1 for 2 edges -> o_q=0; release reset -> o_q=5 after the next edge.
- Sweep: select stepped 0,1,2,…,10, one value per clock (data as above) -> o_q sequence, lagging by one clock: 14,4,23,5,6,8,12,23,23,1,2.
- Upper indices: select=11,12,13,14 on consecutive clocks -> o_q = 3,22,33,44, each one clock after select applied.
- Out of range: select=15 -> o_q=0 after one edge. Then select=14 -> o_q=44.
- Data tracking with latency: hold select=9, change d9 from 1 to 12'hFFF -> o_q=1 until the next edge, then 12'hFFF. Changing d8 leaves o_q unaffected.
- Mid-operation reset: select=13 (o_q=33), assert reset for one edge -> o_q=0. Deassert with select still 13 -> o_q=33 on the following edge.
